// File: rtl/mcpu_alu.sv
`timescale 1ns/1ps
// mcpu_alu: one-cycle registered ALU (AND / OR / XOR / unsigned ADD).
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - synchronous active-high reset; clears out and OVERFLOW
//   opcode   - CMD_SIZE-bit operation select; unmatched codes add
//   r1, r2   - WORD_SIZE-bit unsigned operands
//   out      - 2*WORD_SIZE-bit registered result, upper bits above the
//              carry position always zero
//   OVERFLOW - registered carry-out of the addition, zero for logic ops
module mcpu_alu #(
    parameter int unsigned           CMD_SIZE  = 2,
    parameter int unsigned           WORD_SIZE = 8,
    parameter logic [CMD_SIZE-1:0]   CMD_AND   = CMD_SIZE'(0),
    parameter logic [CMD_SIZE-1:0]   CMD_OR    = CMD_SIZE'(1),
    parameter logic [CMD_SIZE-1:0]   CMD_XOR   = CMD_SIZE'(2),
    parameter logic [CMD_SIZE-1:0]   CMD_ADD   = CMD_SIZE'(3)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CMD_SIZE-1:0]      opcode,
    input  logic [WORD_SIZE-1:0]     r1,
    input  logic [WORD_SIZE-1:0]     r2,
    output logic [2*WORD_SIZE-1:0]   out,
    output logic                     OVERFLOW
);

    localparam int unsigned OUT_W = 2 * WORD_SIZE;
    localparam int unsigned SUM_W = WORD_SIZE + 1;

    logic [SUM_W-1:0] sum_c;
    logic [OUT_W-1:0] result_c;
    logic             carry_c;

    // CMD_ADD needs no explicit match: every non-logic opcode falls through
    // to addition, so the parameter only documents the canonical add code.
    logic unused_add_c;
    assign unused_add_c = ^CMD_ADD;

    // Next result: logic ops are zero-extended, everything else adds.
    always_comb begin
        sum_c    = SUM_W'(r1) + SUM_W'(r2);
        result_c = '0;
        carry_c  = 1'b0;
        if (opcode == CMD_AND) begin
            result_c = OUT_W'(r1 & r2);
        end else if (opcode == CMD_OR) begin
            result_c = OUT_W'(r1 | r2);
        end else if (opcode == CMD_XOR) begin
            result_c = OUT_W'(r1 ^ r2);
        end else begin
            result_c = OUT_W'(sum_c);
            carry_c  = sum_c[WORD_SIZE];
        end
    end

    // Output register; reset wins over the operation sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            out      <= result_c;
            OVERFLOW <= carry_c;
        end
    end

endmodule

// File: tb/tb_mcpu_alu.sv
`timescale 1ns/1ps
// tb_mcpu_alu: directed and random checks of mcpu_alu at WORD_SIZE=2,
// CMD_SIZE=2 against an integer-arithmetic reference model.
module tb_mcpu_alu;

    logic       clk;
    logic       rst;
    logic [1:0] opcode;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [3:0] out;
    logic       OVERFLOW;

    int total;
    int bad;

    mcpu_alu #(
        .CMD_SIZE (2),
        .WORD_SIZE(2),
        .CMD_AND  (2'd0),
        .CMD_OR   (2'd1),
        .CMD_XOR  (2'd2),
        .CMD_ADD  (2'd3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .r1      (r1),
        .r2      (r2),
        .out     (out),
        .OVERFLOW(OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value of the operation as a plain integer.
    function automatic int ref_value(input int op, input int a, input int b, input bit r);
        if (r) return 0;
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Apply inputs, clock once, then compare the registered result.
    task automatic step(input string tag, input int op, input int a, input int b, input bit r);
        int exp_val;
        logic [3:0] exp_out;
        logic       exp_ovf;
        rst    = r;
        opcode = 2'(op);
        r1     = 2'(a);
        r2     = 2'(b);
        exp_val = ref_value(op, a, b, r);
        exp_out = 4'(exp_val);
        exp_ovf = (op == 3 && !r && exp_val > 3) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        total++;
        assert (out === exp_out) else begin
            bad++;
            $error("FAIL %s out: got=%b exp=%b", tag, out, exp_out);
        end
        total++;
        assert (OVERFLOW === exp_ovf) else begin
            bad++;
            $error("FAIL %s ovf: got=%b exp=%b", tag, OVERFLOW, exp_ovf);
        end
    endtask

    initial begin
        int op;
        int a;
        int b;
        bit r;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        opcode = 2'd0;
        r1     = 2'd0;
        r2     = 2'd0;

        // Reset with an overflowing add present on the inputs.
        step("reset_add33", 3, 3, 3, 1'b1);

        // Logic operations.
        step("and_11_10", 0, 3, 2, 1'b0);
        step("or_01_10",  1, 1, 2, 1'b0);
        step("xor_11_01", 2, 3, 1, 1'b0);

        // Addition with and without carry.
        step("add_3_3", 3, 3, 3, 1'b0);
        step("add_1_1", 3, 1, 1, 1'b0);

        // Back-to-back AND, ADD with carry, XOR.
        step("b2b_and",  0, 2, 3, 1'b0);
        step("b2b_add",  3, 3, 1, 1'b0);
        step("b2b_xor",  2, 2, 3, 1'b0);

        // Reset on the edge that samples a carrying add; no carry afterwards.
        step("add_pre",     3, 2, 2, 1'b0);
        step("rst_on_add",  3, 3, 3, 1'b1);
        step("post_rst_or", 1, 0, 0, 1'b0);
        step("post_rst_add", 3, 0, 3, 1'b0);

        // Boundary: zero operands and all-ones logic ops.
        step("and_zero", 0, 0, 3, 1'b0);
        step("or_ones",  1, 3, 3, 1'b0);
        step("xor_same", 2, 3, 3, 1'b0);
        step("add_zero", 3, 0, 0, 1'b0);

        // Random operations with occasional reset.
        for (int i = 0; i < 1200; i++) begin
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 3));
            b  = int'($urandom_range(0, 3));
            r  = ($urandom_range(0, 49) == 0);
            step("random", op, a, b, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
